// File: rtl/posit_mul_arbiter_if.sv
// Requester-side bundle for posit_mul_arbiter: two operand request channels
// plus the shared, tagged result return.
interface posit_mul_arbiter_if #(
  parameter int N = 32
);
  logic         req0_valid;
  logic         req1_valid;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         req0_ready;
  logic         req1_ready;
  logic         res0_valid;
  logic         res1_valid;
  logic [N-1:0] res_data;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output req0_ready, req1_ready, res0_valid, res1_valid, res_data
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  req0_ready, req1_ready, res0_valid, res1_valid, res_data
  );
endinterface

// File: rtl/posit_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined posit multiplier between two
// requesters; a tag FIFO routes in-order results back to their owner.
module posit_mul_arbiter #(
  parameter int N     = 32,
  parameter int es    = 2,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int OW   = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  posit_mul_arbiter_if.slave   req_if,
  output logic [N-1:0]         mul_in1,
  output logic [N-1:0]         mul_in2,
  output logic                 mul_start,
  input  logic [N-1:0]         mul_out,
  input  logic                 mul_done,
  output logic [OW-1:0]        outstanding,
  output logic                 err_underflow
);

  // Handshake: a request transfers on a rising edge where valid and ready are
  // both 1; ready is combinational, at most one requester is granted, and no
  // grant is given while the tag FIFO is full (a same-cycle pop does not help).

  logic             full;
  logic             grant0;
  logic             grant1;
  logic             push;
  logic             pop;
  logic             head_tag;

  logic [DEPTH-1:0] tag_q, tag_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [N-1:0]     mul_in1_q, mul_in1_d;
  logic [N-1:0]     mul_in2_q, mul_in2_d;
  logic             mul_start_q, mul_start_d;
  logic             res0_valid_q, res0_valid_d;
  logic             res1_valid_q, res1_valid_d;
  logic [N-1:0]     res_data_q, res_data_d;
  logic             err_q, err_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b1 & 1'b0;
    full   = (cnt_q == OW'(DEPTH));
    if (!rst && !full) begin
      if (req_if.req0_valid && req_if.req1_valid) begin
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
      end else if (req_if.req0_valid) begin
        grant0 = 1'b1;
      end else if (req_if.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign push     = grant0 | grant1;
  assign pop      = mul_done && (cnt_q != '0);
  assign head_tag = tag_q[rd_ptr_q];

  always_comb begin
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mul_in1_d    = mul_in1_q;
    mul_in2_d    = mul_in2_q;
    mul_start_d  = 1'b0;
    res0_valid_d = 1'b0;
    res1_valid_d = 1'b0;
    res_data_d   = res_data_q;
    err_d        = err_q;

    if (push) begin
      tag_d[wr_ptr_q] = grant1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      last_grant_d    = grant1;
      mul_start_d     = 1'b1;
      mul_in1_d       = grant1 ? req_if.req1_a : req_if.req0_a;
      mul_in2_d       = grant1 ? req_if.req1_b : req_if.req0_b;
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      res_data_d   = mul_out;
      res0_valid_d = !head_tag;
      res1_valid_d = head_tag;
    end else if (mul_done) begin
      err_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + OW'(1);
      2'b01:   cnt_d = cnt_q - OW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      mul_in1_q    <= '0;
      mul_in2_q    <= '0;
      mul_start_q  <= 1'b0;
      res0_valid_q <= 1'b0;
      res1_valid_q <= 1'b0;
      res_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mul_in1_q    <= mul_in1_d;
      mul_in2_q    <= mul_in2_d;
      mul_start_q  <= mul_start_d;
      res0_valid_q <= res0_valid_d;
      res1_valid_q <= res1_valid_d;
      res_data_q   <= res_data_d;
      err_q        <= err_d;
    end
  end

  assign req_if.req0_ready = grant0;
  assign req_if.req1_ready = grant1;
  assign req_if.res0_valid = res0_valid_q;
  assign req_if.res1_valid = res1_valid_q;
  assign req_if.res_data   = res_data_q;
  assign mul_in1           = mul_in1_q;
  assign mul_in2           = mul_in2_q;
  assign mul_start         = mul_start_q;
  assign outstanding       = cnt_q;
  assign err_underflow     = err_q;

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Bench for posit_mul_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_posit_mul_arbiter;
  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int LAT   = 4;
  localparam logic [N-1:0] ONE = 32'h40000000;
  localparam logic [N-1:0] TWO = 32'h48000000;

  logic         clk;
  logic         rst;
  logic [N-1:0] mul_in1, mul_in2, mul_out;
  logic         mul_start, mul_done;
  logic [3:0]   outstanding;
  logic         err_underflow;

  posit_mul_arbiter_if #(.N(N)) bus();

  posit_mul_arbiter #(.N(N), .es(2), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_if        (bus),
    .mul_in1       (mul_in1),
    .mul_in2       (mul_in2),
    .mul_start     (mul_start),
    .mul_out       (mul_out),
    .mul_done      (mul_done),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // multiplier model: in-order pending results with due cycle
  logic [N-1:0] pend_d[$];
  int           pend_t[$];
  bit           hold   = 1'b0;
  bit           inject = 1'b0;

  // reference model of the arbiter
  int           tags[$];
  logic [N:0]   exp_q[$];
  bit           lg;
  bit           err_m, ms_m, r0_m, r1_m;
  logic [N-1:0] mi1_m, mi2_m, rd_m;
  int           dut_grant;

  typedef struct {
    bit v0;
    bit v1;
    bit r0;
    bit r1;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [N-1:0] fake_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a == ONE) return b;
    if (b == ONE) return a;
    return a ^ {b[N-2:0], b[N-1]} ^ 32'h5a5a5a5a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    tags.delete();
    exp_q.delete();
    lg    = 1'b1;
    err_m = 1'b0;
    ms_m  = 1'b0;
    r0_m  = 1'b0;
    r1_m  = 1'b0;
    mi1_m = '0;
    mi2_m = '0;
    rd_m  = '0;
  endtask

  // driver: one clock cycle of checks, multiplier response, stimulus, prediction
  task automatic step(input bit v0, input bit v1, input logic [N-1:0] a0, input logic [N-1:0] b0,
                      input logic [N-1:0] a1, input logic [N-1:0] b1);
    int         g;
    int         t;
    logic [N:0] e;
    @(posedge clk);
    #1;
    cyc++;
    check("mul_start", mul_start, ms_m);
    check("mul_in1", mul_in1, mi1_m);
    check("mul_in2", mul_in2, mi2_m);
    check("res0_valid", bus.res0_valid, r0_m);
    check("res1_valid", bus.res1_valid, r1_m);
    check("res_data", bus.res_data, rd_m);
    check("outstanding", outstanding, tags.size());
    check("err_underflow", err_underflow, err_m);
    if (bus.res0_valid || bus.res1_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", {bus.res1_valid, bus.res_data}, e);
      end
    end

    if (mul_start) begin
      pend_d.push_back(fake_mul(mul_in1, mul_in2));
      pend_t.push_back(cyc + LAT);
    end
    mul_done = 1'b0;
    mul_out  = $urandom;
    if (inject) begin
      mul_done = 1'b1;
    end else if (!hold && pend_d.size() > 0 && pend_t[0] <= cyc) begin
      mul_done = 1'b1;
      mul_out  = pend_d.pop_front();
      void'(pend_t.pop_front());
    end

    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
    #1;

    g = -1;
    if (tags.size() < DEPTH) begin
      if (v0 && v1) g = lg ? 0 : 1;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    dut_grant = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : -1);
    check("req0_ready", bus.req0_ready, g == 0);
    check("req1_ready", bus.req1_ready, g == 1);

    r0_m = 1'b0;
    r1_m = 1'b0;
    if (mul_done && tags.size() > 0) begin
      t    = tags.pop_front();
      r0_m = (t == 0);
      r1_m = (t == 1);
      rd_m = mul_out;
    end else if (mul_done) begin
      err_m = 1'b1;
    end
    ms_m = (g >= 0);
    if (g >= 0) begin
      mi1_m = (g == 1) ? a1 : a0;
      mi2_m = (g == 1) ? b1 : b0;
      tags.push_back(g);
      exp_q.push_back({(g == 1), fake_mul(mi1_m, mi2_m)});
      lg = (g == 1);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic rand_step(input bit v0, input bit v1);
    step(v0, v1, $urandom, $urandom, $urandom, $urandom);
  endtask

  // reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_in1", mul_in1, 0);
    check("rst_mul_in2", mul_in2, 0);
    check("rst_res0", bus.res0_valid, 0);
    check("rst_res1", bus.res1_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_underflow, 0);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    model_reset();
    mul_done       = 1'b0;
    inject         = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok   = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 200; i++) begin
      idle();
      if (tags.size() == 0 && pend_d.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    idle();
    check("drain_done", ok, 1);
    check("drain_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit dp;
    bit got;
    int cnt;

    tbl[0] = '{v0: 1'b0, v1: 1'b0, r0: 1'b0, r1: 1'b0};
    tbl[1] = '{v0: 1'b1, v1: 1'b0, r0: 1'b1, r1: 1'b0};
    tbl[2] = '{v0: 1'b1, v1: 1'b1, r0: 1'b0, r1: 1'b1};
    tbl[3] = '{v0: 1'b1, v1: 1'b1, r0: 1'b1, r1: 1'b0};
    tbl[4] = '{v0: 1'b0, v1: 1'b1, r0: 1'b0, r1: 1'b1};
    tbl[5] = '{v0: 1'b1, v1: 1'b1, r0: 1'b1, r1: 1'b0};
    tbl[6] = '{v0: 1'b0, v1: 1'b1, r0: 1'b0, r1: 1'b1};
    tbl[7] = '{v0: 1'b0, v1: 1'b0, r0: 1'b0, r1: 1'b0};

    rst            = 1'b1;
    mul_done       = 1'b0;
    mul_out        = '0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    #3;
    do_reset();

    // single request 1.0 * 2.0
    step(1'b1, 1'b0, ONE, TWO, '0, '0);
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      dp = mul_done;
      idle();
      if (k == 0) check("single_mul_start", mul_start, 1);
      check("single_res0_after_done", bus.res0_valid, dp);
      check("single_res1_quiet", bus.res1_valid, 0);
      if (bus.res0_valid) begin
        got = 1'b1;
        check("single_res_data", bus.res_data, TWO);
      end
    end
    check("single_seen", got, 1);

    // directed grant table from a fresh reset
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rand_step(tbl[k].v0, tbl[k].v1);
      check("tbl_ready0", bus.req0_ready, tbl[k].r0);
      check("tbl_ready1", bus.req1_ready, tbl[k].r1);
    end
    drain();

    // contention: alternating grants starting with req0
    do_reset();
    for (int k = 0; k < 6; k++) begin
      rand_step(1'b1, 1'b1);
      check("rr_grant", dut_grant, k % 2);
    end
    drain();

    // full: multiplier stalled, both requesters pushing
    do_reset();
    hold = 1'b1;
    cnt  = 0;
    for (int k = 0; k < 14; k++) begin
      rand_step(1'b1, 1'b1);
      if (dut_grant >= 0) cnt++;
    end
    check("full_transfers", cnt, DEPTH);
    check("full_outstanding", outstanding, DEPTH);
    check("full_ready0", bus.req0_ready, 0);
    check("full_ready1", bus.req1_ready, 0);
    hold = 1'b0;
    rand_step(1'b1, 1'b1);
    check("full_pop_no_bypass", bus.req0_ready | bus.req1_ready, 0);
    rand_step(1'b1, 1'b1);
    check("full_reopen", dut_grant >= 0, 1);
    drain();

    // simultaneous push and pop with three outstanding
    do_reset();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) rand_step(1'b1, 1'b0);
    for (int k = 0; k < 6; k++) idle();
    hold = 1'b0;
    rand_step(1'b0, 1'b1);
    hold = 1'b1;
    check("pp_done", mul_done, 1);
    check("pp_grant", dut_grant, 1);
    idle();
    check("pp_outstanding", outstanding, 3);
    check("pp_res0", bus.res0_valid, 1);
    check("pp_mul_start", mul_start, 1);
    drain();

    // underflow: spurious mul_done with nothing outstanding
    do_reset();
    inject = 1'b1;
    idle();
    inject = 1'b0;
    idle();
    check("uf_err", err_underflow, 1);
    check("uf_no_strobe", bus.res0_valid | bus.res1_valid, 0);
    for (int k = 0; k < 3; k++) idle();
    check("uf_sticky", err_underflow, 1);

    // mid-run reset with five in flight; stale completions flag underflow
    do_reset();
    hold = 1'b1;
    for (int k = 0; k < 5; k++) rand_step(1'b1, 1'b0);
    idle();
    check("mr_outstanding", outstanding, 5);
    do_reset();
    drain();
    check("mr_stale_err", err_underflow, 1);
    rand_step(1'b1, 1'b1);
    check("mr_first_grant", dut_grant, 0);
    drain();

    // randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      rand_step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/posit_mul_arbiter.md
POSIT_MUL_ARBITER -- requirements
Module: posit_mul_arbiter

Interface
REQ-001 Parameter N, default 32: posit word width.
REQ-002 Parameter es, default 2: posit exponent field width; it SHALL be passed through unchanged and SHALL NOT be used internally.
REQ-003 Parameter DEPTH, default 8: tag-FIFO depth, the maximum number of outstanding multiplies; it SHALL be a power of two and at least 2.
REQ-004 clk  in  1  the single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req0_valid, req1_valid  in  1 each  requester K has an operand pair.
REQ-007 req0_a, req0_b, req1_a, req1_b  in  N each  operand posits.
REQ-008 req0_ready, req1_ready  out  1 each  grant; combinational.
REQ-009 res0_valid, res1_valid  out  1 each  one-cycle result strobe; registered.
REQ-010 res_data  out  N  product, shared by both requesters; registered.
REQ-011 mul_in1, mul_in2  out  N each  operands to the shared pipelined posit multiplier.
REQ-012 mul_start  out  1  one-cycle issue strobe to the multiplier.
REQ-013 mul_out  in  N  multiplier result.
REQ-014 mul_done  in  1  multiplier result-valid strobe; results return in issue order.
REQ-015 outstanding  out  clog2(DEPTH)+1  number of in-flight multiplies.
REQ-016 err_underflow  out  1  sticky: mul_done was seen with no outstanding tag.

Function
REQ-017 Handshake: a request transfers on a rising edge where reqK_valid and reqK_ready are both 1.
REQ-018 Ready gating: reqK_ready SHALL be 0 whenever outstanding == DEPTH. Issue is blocked when full even if a pop occurs in the same cycle (no bypass).
REQ-019 Single grant: at most one of req0_ready and req1_ready SHALL be 1 in any cycle.
REQ-020 Single requester: if only one reqK_valid is 1 and the FIFO is not full, that requester's ready SHALL be 1.
REQ-021 Round-robin: if both valids are 1 and the FIFO is not full, grant the requester other than last_grant.
REQ-022 last_grant SHALL update only on a completed transfer. After reset it holds 1, so req0 wins the first contention.
REQ-023 Ready while idle: when no valid is asserted, both readies SHALL be 0.
REQ-024 Issue timing: on a transfer edge, mul_in1 <= reqK_a, mul_in2 <= reqK_b, mul_start <= 1, and tag K is pushed.
REQ-025 mul_start SHALL be 0 on every edge without a transfer; mul_in1/mul_in2 hold their last value.
REQ-026 Completion timing: on an edge where mul_done == 1 and outstanding > 0, the head tag T is popped, res_data <= mul_out, resT_valid <= 1, and the other strobe <= 0.
REQ-027 Strobe width: resK_valid SHALL be 0 on every edge without a valid completion. Latency from transfer edge to resK_valid is the multiplier latency plus 2 cycles.
REQ-028 Counting: outstanding +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-029 FIFO pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-030 Underflow: on an edge with mul_done == 1 and outstanding == 0, there is no pop, both res strobes stay 0, res_data holds, and err_underflow <= 1; it clears only on reset.
REQ-031 Arithmetic: operands and results pass through bit-exact; no arithmetic on posit values.

Reset
REQ-032 While rst == 1, asynchronously: mul_start = 0, mul_in1 = mul_in2 = 0, res0_valid = res1_valid = 0, res_data = 0, outstanding = 0, FIFO pointers = 0, last_grant = 1, err_underflow = 0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight tags. mul_done strobes arriving after reset deassertion for pre-reset issues SHALL set err_underflow.
REQ-034 Readies SHALL be 0 while rst == 1.

Verification
REQ-035 Setup: N=32, es=2, DEPTH=8; the bench models the multiplier with a fixed 4-cycle latency.
REQ-036 Single request: req0 with a=0x40000000 (1.0), b=0x48000000 (2.0) -> mul_start one cycle after transfer; res0_valid one cycle after mul_done; res_data=0x48000000; res1_valid stays 0.
REQ-037 Contention: req0 and req1 valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; results return tagged in the same order.
REQ-038 Full: mul_done held 0, both requesters valid -> exactly 8 transfers; outstanding=8; readies stay 0 until the first pop.
REQ-039 Simultaneous push/pop: outstanding=3, a transfer and mul_done on the same edge -> outstanding stays 3; a correct strobe is issued.
REQ-040 Underflow: mul_done pulse with outstanding=0 -> err_underflow=1; no res strobe; the flag holds until rst.
REQ-041 Mid-run reset: rst pulsed with 5 outstanding -> all outputs take REQ-032 values immediately; the next transfer is granted to req0 on contention.
